enemigo_mover: RTL and testbench

Motion controller that drives the position and enable inputs of the enemy sprite renderer in the VGA game pipeline. The enemy spawns in a pseudo-random road lane, moves down one step per frame and despawns at the screen bottom. A hit from the collision detector triggers a blink sequence. Position changes only during vertical blanking, so the renderer always sees a stable sprite within a frame.

---
 rtl/enemigo_mover_pkg.sv | 22 ++
 rtl/enemigo_mover_lfsr8.sv | 32 +++
 rtl/enemigo_mover.sv | 160 ++++++++++++++++
 tb/tb_enemigo_mover.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/enemigo_mover_pkg.sv
// Shared definitions for the enemy motion controller and the sprite renderers.
package enemigo_mover_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_MOVE = 2'd2,
      ST_HIT  = 2'd3
   } state_t;

   localparam logic [7:0] LFSR_SEED   = 8'hA5;
   // Taps 8,6,5,4 mapped onto bits 7,5,4,3 of a left-shifting register.
   localparam logic [7:0] LFSR_TAPS   = 8'hB8;
   localparam int unsigned LANE_COUNT  = 3;
   localparam int unsigned SPRITE_SIZE = 60;

   // Two random bits give four codes but only three lanes; the spare code folds onto the centre lane.
   function automatic logic [1:0] lane_of(input logic [1:0] r);
      return (r >= 2'(LANE_COUNT)) ? 2'd1 : r;
   endfunction

endpackage

// File: rtl/enemigo_mover_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to pick the spawn lane.
module lfsr8
   import enemigo_mover_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   output logic [7:0] q
);

   logic [7:0] q_reg;
   logic [7:0] q_next;

   // Maximal-length polynomial from a non-zero seed, so the all-zero lock-up state is never reached.
   assign q_next[0] = ^(q_reg & LFSR_TAPS);

   generate
      for (genvar gi = 1; gi < 8; gi++) begin : g_shift
         assign q_next[gi] = q_reg[gi-1];
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         q_reg <= LFSR_SEED;
      end else begin
         q_reg <= q_next;
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/enemigo_mover.sv
// Enemy sprite motion controller: spawn in a random lane, fall one step per frame, blink when hit.
module enemigo_mover
   import enemigo_mover_pkg::*;
#(
   parameter int unsigned LANE_X0     = 200,
   parameter int unsigned LANE_STEP   = 80,
   parameter int unsigned SCREEN_H    = 480,
   parameter int unsigned SPEED_INIT  = 2,
   parameter int unsigned SPEED_MAX   = 8,
   parameter int unsigned SPAWN_DELAY = 30,
   parameter int unsigned HIT_FRAMES  = 32
)(
   input  logic       clock,
   input  logic       reset,
   input  logic [9:0] hcount,
   input  logic [9:0] vcount,
   input  logic       run,
   input  logic       hit,
   output logic [9:0] posx,
   output logic [9:0] posy,
   output logic       enable,
   output logic       passed,
   output logic [3:0] speed
);

   localparam int unsigned CNT_MAX = (SPAWN_DELAY > HIT_FRAMES) ? SPAWN_DELAY : HIT_FRAMES;
   localparam int unsigned CNT_W   = (CNT_MAX < 7) ? 3 : $clog2(CNT_MAX + 1);

   state_t           state_reg,  state_next;
   logic [CNT_W-1:0] cnt_reg,    cnt_next;
   logic [2:0]       pass_reg,   pass_next;
   logic [9:0]       posx_reg,   posx_next;
   logic [9:0]       posy_reg,   posy_next;
   logic             enable_reg, enable_next;
   logic             passed_reg, passed_next;
   logic [3:0]       speed_reg,  speed_next;

   logic [7:0]       lfsr_q;
   logic             unused_lfsr;
   logic [1:0]       lane;
   logic             tick;
   logic [CNT_W-1:0] cnt_inc;
   logic [10:0]      posy_sum;
   logic             at_bottom;

   lfsr8 u_lfsr (
      .clock (clock),
      .reset (reset),
      .q     (lfsr_q)
   );

   assign unused_lfsr = ^lfsr_q[7:2];
   assign lane        = lane_of(lfsr_q[1:0]);
   assign tick        = (hcount == 10'd0) && (vcount == 10'(SCREEN_H));
   assign cnt_inc     = cnt_reg + 1'b1;
   // Eleven bits so a step near the bottom cannot wrap back to a small y.
   assign posy_sum    = {1'b0, posy_reg} + {7'd0, speed_reg};
   assign at_bottom   = (posy_sum >= 11'(SCREEN_H));

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      pass_next   = pass_reg;
      posx_next   = posx_reg;
      posy_next   = posy_reg;
      enable_next = enable_reg;
      passed_next = 1'b0;
      speed_next  = speed_reg;

      if (!run) begin
         state_next  = ST_IDLE;
         enable_next = 1'b0;
      end else begin
         unique case (state_reg)
            ST_IDLE: begin
               speed_next = 4'(SPEED_INIT);
               pass_next  = '0;
               cnt_next   = '0;
               state_next = ST_WAIT;
            end
            ST_WAIT: begin
               if (tick) begin
                  if (cnt_inc == CNT_W'(SPAWN_DELAY)) begin
                     cnt_next    = '0;
                     posx_next   = 10'(LANE_X0 + LANE_STEP * {30'd0, lane});
                     posy_next   = '0;
                     enable_next = 1'b1;
                     state_next  = ST_MOVE;
                  end else begin
                     cnt_next = cnt_inc;
                  end
               end
            end
            ST_MOVE: begin
               // A hit pre-empts both the frame step and the bottom exit.
               if (hit) begin
                  cnt_next    = '0;
                  enable_next = 1'b0;
                  state_next  = ST_HIT;
               end else if (tick) begin
                  if (at_bottom) begin
                     passed_next = 1'b1;
                     enable_next = 1'b0;
                     cnt_next    = '0;
                     state_next  = ST_WAIT;
                     pass_next   = pass_reg + 1'b1;
                     if (pass_reg == 3'd7 && speed_reg < 4'(SPEED_MAX)) begin
                        speed_next = speed_reg + 1'b1;
                     end
                  end else begin
                     posy_next = posy_sum[9:0];
                  end
               end
            end
            ST_HIT: begin
               if (tick) begin
                  if (cnt_inc == CNT_W'(HIT_FRAMES)) begin
                     cnt_next    = '0;
                     enable_next = 1'b0;
                     state_next  = ST_WAIT;
                  end else begin
                     cnt_next    = cnt_inc;
                     enable_next = cnt_inc[2];
                  end
               end
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         pass_reg   <= '0;
         posx_reg   <= 10'(LANE_X0 + LANE_STEP);
         posy_reg   <= '0;
         enable_reg <= 1'b0;
         passed_reg <= 1'b0;
         speed_reg  <= 4'(SPEED_INIT);
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         pass_reg   <= pass_next;
         posx_reg   <= posx_next;
         posy_reg   <= posy_next;
         enable_reg <= enable_next;
         passed_reg <= passed_next;
         speed_reg  <= speed_next;
      end
   end

   assign posx   = posx_reg;
   assign posy   = posy_reg;
   assign enable = enable_reg;
   assign passed = passed_reg;
   assign speed  = speed_reg;

endmodule

// File: tb/tb_enemigo_mover.sv
// Scoreboard bench for enemigo_mover: a frame-level reference model predicts every clock's outputs.
module tb_enemigo_mover;

   logic       clock = 1'b0;
   logic       reset;
   logic [9:0] hcount, vcount;
   logic       run, hit;
   logic [9:0] posx, posy;
   logic       enable, passed;
   logic [3:0] speed;

   always #5 clock = ~clock;

   enemigo_mover dut (
      .clock  (clock),
      .reset  (reset),
      .hcount (hcount),
      .vcount (vcount),
      .run    (run),
      .hit    (hit),
      .posx   (posx),
      .posy   (posy),
      .enable (enable),
      .passed (passed),
      .speed  (speed)
   );

   typedef struct packed {
      logic [9:0] posy;
      logic       enable;
      logic       passed;
      logic [3:0] speed;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   dut_passes = 0;

   // Reference model: 0 idle, 1 wait, 2 move, 3 hit
   int m_state, m_cnt, m_posy, m_speed, m_pc;
   bit m_en, m_passed;

   task automatic check(input string tag, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_posy = 0; m_speed = 2; m_pc = 0;
      m_en = 0; m_passed = 0;
   endtask

   task automatic model_clock(input bit tk, input bit h, input bit r);
      m_passed = 0;
      if (!r) begin
         m_state = 0;
         m_en    = 0;
      end else begin
         case (m_state)
            0: begin m_speed = 2; m_pc = 0; m_cnt = 0; m_state = 1; end
            1: if (tk) begin
                  m_cnt++;
                  if (m_cnt == 30) begin m_cnt = 0; m_posy = 0; m_en = 1; m_state = 2; end
               end
            2: if (h) begin
                  m_state = 3; m_cnt = 0; m_en = 0;
               end else if (tk) begin
                  if (m_posy + m_speed >= 480) begin
                     m_passed = 1; m_en = 0; m_state = 1; m_cnt = 0;
                     if (m_pc == 7 && m_speed < 8) m_speed++;
                     m_pc = (m_pc + 1) % 8;
                  end else begin
                     m_posy += m_speed;
                  end
               end
            default: if (tk) begin
                  m_cnt++;
                  if (m_cnt == 32) begin m_state = 1; m_cnt = 0; m_en = 0; end
                  else m_en = ((m_cnt >> 2) & 1) != 0;
               end
         endcase
      end
   endtask

   task automatic step(input bit tk, input bit h, input bit r);
      exp_t e;
      @(negedge clock);
      reset = 1'b0;
      if (tk) begin
         hcount = 10'd0; vcount = 10'd480;
      end else if ($urandom_range(0, 1) == 1) begin
         hcount = 10'($urandom_range(1, 799)); vcount = 10'd480;
      end else begin
         hcount = 10'd0; vcount = 10'($urandom_range(0, 479));
      end
      hit = h;
      run = r;
      model_clock(tk, h, r);
      e.posy = 10'(m_posy); e.enable = m_en; e.passed = m_passed; e.speed = 4'(m_speed);
      sb_q.push_back(e);
      @(posedge clock);
      #1;
      e = sb_q.pop_front();
      if (passed) dut_passes++;
      check("posy",   int'(posy),   int'(e.posy));
      check("enable", int'(enable), int'(e.enable));
      check("passed", int'(passed), int'(e.passed));
      check("speed",  int'(speed),  int'(e.speed));
      check("posx_in_lane", int'(posx == 10'd200 || posx == 10'd280 || posx == 10'd360), 1);
   endtask

   task automatic frame(input bit h);
      step(1'b1, h, 1'b1);
      step(1'b0, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; hit = 1'b0; hcount = 10'd0; vcount = 10'd480;
      model_reset();
      sb_q.delete();
      repeat (2) @(posedge clock);
      #1;
      check("rst_posx",   int'(posx),   280);
      check("rst_posy",   int'(posy),   0);
      check("rst_enable", int'(enable), 0);
      check("rst_passed", int'(passed), 0);
      check("rst_speed",  int'(speed),  2);
   endtask

   task automatic wait_spawn(input int want);
      int n = 0;
      while (!enable && n < 100) begin
         frame(1'b0);
         n++;
      end
      check("spawn_ticks", n, want);
      check("spawn_posy", int'(posy), 0);
   endtask

   task automatic frames_until_posy(input int target);
      int g = 0;
      while (m_posy != target && g < 400) begin
         frame(1'b0);
         g++;
      end
      check("reach_posy", int'(posy), target);
   endtask

   task automatic run_passes(input int n);
      int start = dut_passes;
      int g = 0;
      while (dut_passes < start + n && g < n * 400) begin
         frame(1'b0);
         g++;
      end
      check("pass_count", dut_passes - start, n);
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; hit = 1'b0; hcount = 10'd0; vcount = 10'd0;
      do_reset();

      // Start the game and wait out the first spawn delay.
      step(1'b0, 1'b0, 1'b1);
      wait_spawn(30);

      // Hit at y=100: frozen position, blinking enable, back to WAIT with no pass.
      frames_until_posy(100);
      step(1'b0, 1'b1, 1'b1);
      repeat (32) frame(1'b0);
      check("hit_posy_frozen", int'(posy), 100);
      check("hit_end_enable", int'(enable), 0);

      // Hits during WAIT, with and without a tick, are ignored.
      frame(1'b1);
      step(1'b0, 1'b1, 1'b1);
      wait_spawn(29);

      // Hit coincident with the exit tick: HIT wins, no pass.
      frames_until_posy(478);
      frame(1'b1);
      repeat (32) frame(1'b0);
      check("no_pass_on_hit", dut_passes, 0);

      run_passes(8);
      check("speed_after_8", int'(speed), 3);

      // Drop run mid-flight, then restart with a reloaded speed.
      wait_spawn(30);
      repeat (5) frame(1'b0);
      step(1'b0, 1'b0, 1'b0);
      check("drop_enable", int'(enable), 0);
      step(1'b1, 1'b0, 1'b0);
      check("drop_speed_held", int'(speed), 3);
      step(1'b0, 1'b0, 1'b1);
      check("reload_speed", int'(speed), 2);
      wait_spawn(30);

      run_passes(48);
      check("speed_max", int'(speed), 8);
      run_passes(8);
      check("speed_saturated", int'(speed), 8);

      // Reset in the middle of a frame, then a normal restart.
      wait_spawn(30);
      repeat (3) frame(1'b0);
      do_reset();
      step(1'b0, 1'b0, 1'b1);
      wait_spawn(30);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
